// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps key-on/key-off requests onto NUM_VOICES voice slots.
// Optional voice stealing when all voices are gated: define VOICE_STEAL_EN.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int VW         = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_on,
  input  logic                  key_off,
  input  logic [3:0]            note,
  input  logic [2:0]            octave,
  output logic                  req_ready,
  input  logic [NUM_VOICES-1:0] voice_idle,
  output logic [NUM_VOICES-1:0] voice_ld,
  output logic [3:0]            voice_note,
  output logic [2:0]            voice_octave,
  output logic [NUM_VOICES-1:0] voice_gate,
  output logic [VW:0]           active_count,
  output logic                  drop
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_LOAD} state_t;

  state_t                  state_q;
  logic                    op_off_q;
  logic [3:0]              key_note_q;
  logic [2:0]              key_oct_q;
  logic [VW-1:0]           tgt_q;
  logic [3:0]              tbl_note_q [NUM_VOICES];
  logic [2:0]              tbl_oct_q  [NUM_VOICES];
  logic [NUM_VOICES-1:0]   gate_q, gate_d;
  logic [NUM_VOICES-1:0]   ld_q;
  logic [VW:0]             cnt_q;
  logic                    drop_q;
  logic                    ready_q;
  logic [3:0]              vnote_q;
  logic [2:0]              voct_q;
`ifdef VOICE_STEAL_EN
  logic [VW-1:0]           steal_q;
`else
  logic [NUM_VOICES-1:0]   match_in;
`endif

  logic [NUM_VOICES-1:0]   match_lat;
  logic [VW:0]             hit_lat, free_idle, free_any;
  logic                    sel_found;
  logic [VW-1:0]           sel_idx;
  logic [NUM_VOICES-1:0]   sel_onehot;

  // Returns {found, index} of the lowest set bit.
  function automatic logic [VW:0] find_lowest(input logic [NUM_VOICES-1:0] vec);
    logic [VW:0] r;
    r = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (vec[i]) r = {1'b1, VW'(i)};
    end
    return r;
  endfunction

  function automatic logic [VW:0] popcount(input logic [NUM_VOICES-1:0] vec);
    logic [VW:0] r;
    r = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      r = r + {{VW{1'b0}}, vec[i]};
    end
    return r;
  endfunction

  always_comb begin
    match_lat = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      match_lat[v] = gate_q[v] && (tbl_note_q[v] == key_note_q) && (tbl_oct_q[v] == key_oct_q);
    end
  end

`ifndef VOICE_STEAL_EN
  // Gates and key table are frozen while idle, so the overflow outcome is known at acceptance.
  always_comb begin
    match_in = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      match_in[v] = gate_q[v] && (tbl_note_q[v] == note) && (tbl_oct_q[v] == octave);
    end
  end
`endif

  always_comb begin
    hit_lat   = find_lowest(match_lat);
    free_idle = find_lowest(~gate_q & voice_idle);
    free_any  = find_lowest(~gate_q);
    sel_found = 1'b1;
    sel_idx   = '0;
    if (hit_lat[VW]) begin
      sel_idx = hit_lat[VW-1:0];
    end else if (free_idle[VW]) begin
      sel_idx = free_idle[VW-1:0];
    end else if (free_any[VW]) begin
      sel_idx = free_any[VW-1:0];
    end else begin
`ifdef VOICE_STEAL_EN
      sel_idx = steal_q;
`else
      sel_found = 1'b0;
`endif
    end
    sel_onehot          = '0;
    sel_onehot[sel_idx] = 1'b1;
  end

  always_comb begin
    gate_d = gate_q;
    if (state_q == S_SEARCH && op_off_q && hit_lat[VW]) begin
      gate_d[hit_lat[VW-1:0]] = 1'b0;
    end else if (state_q == S_LOAD) begin
      gate_d[tgt_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_off_q   <= 1'b0;
      key_note_q <= '0;
      key_oct_q  <= '0;
      tgt_q      <= '0;
      gate_q     <= '0;
      cnt_q      <= '0;
      ld_q       <= '0;
      drop_q     <= 1'b0;
      ready_q    <= 1'b1;
      vnote_q    <= '0;
      voct_q     <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        tbl_note_q[v] <= '0;
        tbl_oct_q[v]  <= '0;
      end
`ifdef VOICE_STEAL_EN
      steal_q    <= '0;
`endif
    end else begin
      ld_q   <= '0;
      drop_q <= 1'b0;
      gate_q <= gate_d;
      cnt_q  <= popcount(gate_d);
      case (state_q)
        S_IDLE: begin
          if (key_off || key_on) begin
            key_note_q <= note;
            key_oct_q  <= octave;
            op_off_q   <= key_off;
            ready_q    <= 1'b0;
            state_q    <= S_SEARCH;
`ifndef VOICE_STEAL_EN
            drop_q     <= !key_off && (&gate_q) && !(|match_in);
`endif
          end
        end
        S_SEARCH: begin
          if (!op_off_q && sel_found) begin
            tgt_q   <= sel_idx;
            ld_q    <= sel_onehot;
            vnote_q <= key_note_q;
            voct_q  <= key_oct_q;
            state_q <= S_LOAD;
`ifdef VOICE_STEAL_EN
            if (!hit_lat[VW] && !free_any[VW]) begin
              steal_q <= (steal_q == VW'(NUM_VOICES - 1)) ? '0 : steal_q + 1'b1;
            end
`endif
          end else begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          tbl_note_q[tgt_q] <= key_note_q;
          tbl_oct_q[tgt_q]  <= key_oct_q;
          state_q           <= S_IDLE;
          ready_q           <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready    = ready_q;
  assign voice_ld     = ld_q;
  assign voice_note   = vnote_q;
  assign voice_octave = voct_q;
  assign voice_gate   = gate_q;
  assign active_count = cnt_q;
  assign drop         = drop_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: expected strobes/drops queued at issue, popped by a monitor.
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int VW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          key_on = 1'b0, key_off = 1'b0;
  logic [3:0]    note = '0;
  logic [2:0]    octave = '0;
  logic [NV-1:0] voice_idle = '1;
  logic          req_ready;
  logic [NV-1:0] voice_ld;
  logic [3:0]    voice_note;
  logic [2:0]    voice_octave;
  logic [NV-1:0] voice_gate;
  logic [VW:0]   active_count;
  logic          drop;

  voice_allocator #(.NUM_VOICES(NV), .VW(VW)) dut (
    .clk(clk), .reset(reset), .key_on(key_on), .key_off(key_off),
    .note(note), .octave(octave), .req_ready(req_ready),
    .voice_idle(voice_idle), .voice_ld(voice_ld), .voice_note(voice_note),
    .voice_octave(voice_octave), .voice_gate(voice_gate),
    .active_count(active_count), .drop(drop)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit            is_drop;
    logic [NV-1:0] vec;
    logic [3:0]    n;
    logic [2:0]    o;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every strobe or drop must match the oldest queued expectation.
  exp_t e;
  bit   ok;
  always @(negedge clk) begin
    if (voice_ld != '0 || drop) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: voice_ld=%b drop=%b, expected no event", voice_ld, drop);
      end else begin
        e = exp_q.pop_front();
        if (e.is_drop) ok = drop && (voice_ld == '0);
        else ok = !drop && voice_ld == e.vec && voice_note == e.n && voice_octave == e.o;
        if (!ok)
          $display("FAIL scoreboard: got ld=%b drop=%b note=%0d oct=%0d, expected ld=%b drop=%b note=%0d oct=%0d",
                   voice_ld, drop, voice_note, voice_octave, e.vec, e.is_drop, e.n, e.o);
        if (!ok) n_fail++;
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!req_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: req_ready=0, expected 1 within 20 cycles");
    end
  endtask

  task automatic send(input bit on, input bit off, input logic [3:0] n, input logic [2:0] o);
    wait_ready();
    key_on = on; key_off = off; note = n; octave = o;
    @(posedge clk); #1;
    key_on = 1'b0; key_off = 1'b0;
  endtask

  task automatic on_ld(input logic [3:0] n, input logic [2:0] o, input logic [NV-1:0] vec);
    exp_t x;
    x.is_drop = 1'b0; x.vec = vec; x.n = n; x.o = o;
    exp_q.push_back(x);
    send(1'b1, 1'b0, n, o);
    wait_ready();
  endtask

  task automatic on_drop(input logic [3:0] n, input logic [2:0] o);
    exp_t x;
    x.is_drop = 1'b1; x.vec = '0; x.n = '0; x.o = '0;
    exp_q.push_back(x);
    send(1'b1, 1'b0, n, o);
    wait_ready();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_ld"}, voice_ld, 0);
    check({tag, "_gate"}, voice_gate, 0);
    check({tag, "_note"}, voice_note, 0);
    check({tag, "_oct"}, voice_octave, 0);
    check({tag, "_cnt"}, active_count, 0);
    check({tag, "_drop"}, drop, 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    check_zero("reset");

    // Single note: latency of strobe and gate
    begin
      exp_t x;
      x.is_drop = 1'b0; x.vec = 4'b0001; x.n = 4'd9; x.o = 3'd4;
      exp_q.push_back(x);
    end
    send(1'b1, 1'b0, 4'd9, 3'd4);
    check("lat_search_ld", voice_ld, 0);
    @(posedge clk); #1;
    check("lat_load_ld", voice_ld, 4'b0001);
    check("lat_load_gate", voice_gate, 0);
    @(posedge clk); #1;
    check("lat_gate", voice_gate, 4'b0001);
    check("lat_cnt", active_count, 1);
    send(1'b0, 1'b1, 4'd9, 3'd4);
    check("off_search_gate", voice_gate, 4'b0001);
    @(posedge clk); #1;
    check("off_gate", voice_gate, 0);
    check("off_cnt", active_count, 0);

    // Fill all four voices, release E4, refill, retrigger, overflow
    do_reset();
    on_ld(4'd0, 3'd4, 4'b0001);
    on_ld(4'd4, 3'd4, 4'b0010);
    on_ld(4'd7, 3'd4, 4'b0100);
    on_ld(4'd11, 3'd4, 4'b1000);
    check("fill_gate", voice_gate, 4'b1111);
    check("fill_cnt", active_count, 4);
    send(1'b0, 1'b1, 4'd4, 3'd4);
    wait_ready();
    check("relE4_gate", voice_gate, 4'b1101);
    check("relE4_cnt", active_count, 3);
    on_ld(4'd4, 3'd4, 4'b0010);
    on_ld(4'd7, 3'd4, 4'b0100);
    check("retrig_full_cnt", active_count, 4);
`ifdef VOICE_STEAL_EN
    on_ld(4'd2, 3'd5, 4'b0001);
    on_ld(4'd5, 3'd5, 4'b0010);
`else
    on_drop(4'd2, 3'd5);
    on_drop(4'd5, 3'd5);
`endif
    check("overflow_gate", voice_gate, 4'b1111);
    check("overflow_cnt", active_count, 4);

    // Retrigger A4, then simultaneous on/off
    do_reset();
    on_ld(4'd9, 3'd4, 4'b0001);
    on_ld(4'd9, 3'd4, 4'b0001);
    check("retrig_cnt", active_count, 1);
    send(1'b1, 1'b1, 4'd9, 3'd4);
    wait_ready();
    check("onoff_gate", voice_gate, 0);
    check("onoff_cnt", active_count, 0);

    // Releasing voice 0 skipped in favour of idle voice 1; then fallback to a releasing voice
    voice_idle = 4'b1110;
    on_ld(4'd3, 3'd2, 4'b0010);
    voice_idle = 4'b0000;
    on_ld(4'd6, 3'd6, 4'b0001);
    check("release_gate", voice_gate, 4'b0011);
    voice_idle = 4'b1111;

    // Reset during LOAD
    begin
      exp_t x;
      x.is_drop = 1'b0; x.vec = 4'b0100; x.n = 4'd1; x.o = 3'd1;
      exp_q.push_back(x);
    end
    send(1'b1, 1'b0, 4'd1, 3'd1);
    @(posedge clk); #1;
    check("rstload_ld", voice_ld, 4'b0100);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check_zero("rstload");

    // Reset during SEARCH: no strobe may follow
    send(1'b1, 1'b0, 4'd2, 3'd2);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("rstsearch_gate", voice_gate, 0);
    check("rstsearch_ready", req_ready, 1);

    // Out-of-range note passes through
    on_ld(4'd14, 3'd7, 4'b0001);
    check("note14_gate", voice_gate, 4'b0001);

    repeat (4) begin @(posedge clk); #1; end
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
